// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one master_i2c between N_REQ requesters.
// It launches each granted transaction, tracks it through m_ready and returns done/err/rdata.
module i2c_master_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 m_enable,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_out,
  input  logic                 m_ready,
  output logic [1:0]           fsm_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, FINISH} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  idx;
  logic [TW-1:0]  cnt;
  logic           abort;
  logic           found;
  logic [PW-1:0]  win;
  logic           at_limit;

  assign fsm_state = state;
  assign at_limit  = (cnt == TMAX);

  // First pending request scanning upward from the one after the last grantee.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= PW'(N_REQ - 1);
      idx       <= '0;
      cnt       <= '0;
      abort     <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      m_enable  <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_in <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found && m_ready) begin
            gnt       <= '0;
            gnt[win]  <= 1'b1;
            m_addr    <= req_addr[7*win +: 7];
            m_rw      <= req_rw[win];
            m_data_in <= req_wdata[8*win +: 8];
            m_enable  <= 1'b1;
            idx       <= win;
            cnt       <= '0;
            state     <= LAUNCH;
          end
        end
        // Enable drops as soon as the master leaves idle so it stops instead of relaunching.
        LAUNCH: begin
          if (!m_ready) begin
            m_enable <= 1'b0;
            cnt      <= '0;
            state    <= BUSY;
          end else if (at_limit) begin
            m_enable <= 1'b0;
            abort    <= 1'b1;
            cnt      <= '0;
            state    <= FINISH;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        BUSY: begin
          if (m_ready) begin
            cnt   <= '0;
            state <= FINISH;
          end else if (at_limit) begin
            abort <= 1'b1;
            cnt   <= '0;
            state <= FINISH;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        FINISH: begin
          done[idx] <= 1'b1;
          err       <= abort;
          if (m_rw && !abort) rdata <= m_data_out;
          gnt       <= '0;
          ptr       <= idx;
          abort     <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: behavioural master/slave model, event monitor and
// a round-robin reference computed from the arbitration rules.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int T  = 40;
  localparam int TW = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [N-1:0]   req_rw = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt, done;
  logic           err, m_enable, m_rw;
  logic [7:0]     rdata, m_data_in;
  logic [6:0]     m_addr;
  logic [7:0]     m_data_out = '0;
  logic           m_ready = 1'b1;
  logic [1:0]     fsm_state;

  i2c_master_arbiter #(.N_REQ(N), .TIMEOUT(T), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_ready(m_ready), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- master / slave model ----------------
  // mode 0 normal, 1 ready stuck high, 2 ready stuck low after launch, 3 ready held low
  int          mode = 0;
  int          ph = 0;
  int          mcnt = 0;
  int          overlap_err = 0;
  logic [6:0]  cur_addr;
  logic        cur_rw;
  logic [7:0]  slave_mem [128];
  logic [15:0] cap_q [$];

  always @(negedge clk) begin
    if (reset) begin
      ph = 0;
      m_ready = 1'b1;
    end else begin
      case (mode)
        1: m_ready = 1'b1;
        3: m_ready = 1'b0;
        default: begin
          case (ph)
            0: begin
              m_ready = 1'b1;
              if (m_enable) begin
                cap_q.push_back({m_addr, m_rw, m_data_in});
                cur_addr = m_addr;
                cur_rw = m_rw;
                mcnt = $urandom_range(1, 4);
                ph = 1;
              end
            end
            1: begin
              mcnt--;
              if (mcnt == 0) begin
                m_ready = 1'b0;
                if (mode == 2) ph = 3;
                else begin
                  mcnt = $urandom_range(4, 12);
                  ph = 2;
                end
              end
            end
            2: begin
              mcnt--;
              if (mcnt == 0) begin
                if (m_enable) overlap_err++;
                if (cur_rw) m_data_out = slave_mem[cur_addr];
                m_ready = 1'b1;
                ph = 0;
              end
            end
            default: begin
              m_ready = 1'b0;
              if (mode != 2) begin
                ph = 0;
                m_ready = 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  int         grant_log [$];
  int         done_log [$];
  int         done_cnt = 0;
  int         onehot_err = 0;
  logic [N-1:0] gnt_prev = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (!$onehot0(gnt)) onehot_err++;
      if (gnt != 0 && gnt_prev == 0)
        for (int i = 0; i < N; i++) if (gnt[i]) grant_log.push_back(i);
      if (done != 0) begin
        done_cnt++;
        if (!$onehot(done)) onehot_err++;
        for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
      end
    end
    gnt_prev = reset ? '0 : gnt;
  end

  // ---------------- reference state ----------------
  int         exp_ptr;
  logic [7:0] exp_rdata;

  function automatic int rr_next(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] g; int lat; logic [6:0] ga; logic [7:0] gd; logic ge;
    logic [N-1:0] dn; logic e; logic [7:0] rd; logic en_end; int en; int bz; bit to;
  } obs_t;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_payload(input int r, input logic [6:0] a, input logic rw, input logic [7:0] d);
    req_addr[7*r +: 7] = a;
    req_rw[r] = rw;
    req_wdata[8*r +: 8] = d;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_ptr = N - 1;
    exp_rdata = 8'h00;
  endtask

  // One transaction from one requester; payload is scrambled after grant.
  task automatic do_txn(input int r, input logic [6:0] a, input logic rw, input logic [7:0] d,
                        output obs_t o);
    o.g = '0; o.lat = 0; o.dn = '0; o.en = 0; o.bz = 0; o.to = 1'b0; o.e = 1'b0;
    o.rd = '0; o.en_end = 1'b0; o.ga = '0; o.gd = '0; o.ge = 1'b0;
    set_payload(r, a, rw, d);
    req[r] = 1'b1;
    while (o.g == 0 && o.lat < 100) begin
      tick();
      o.lat++;
      o.g = gnt; o.ga = m_addr; o.gd = m_data_in; o.ge = m_enable;
    end
    req[r] = 1'b0;
    set_payload(r, ~a, ~rw, ~d);
    if (o.g == 0) begin
      o.to = 1'b1;
      return;
    end
    for (int k = 0; k < 5000; k++) begin
      if (m_enable) o.en++; else o.bz++;
      tick();
      if (done != 0) begin
        o.dn = done; o.e = err; o.rd = rdata; o.en_end = m_enable;
        break;
      end
    end
    if (o.dn == 0) o.to = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL reset_gnt_done: gnt=%b done=%b required 0", gnt, done); end
    checks++; if (err !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL reset_err_rdata: err=%b rdata=%h required 0", err, rdata); end
    checks++; if ({m_enable, m_addr, m_rw, m_data_in} !== 17'h0) begin errors++; $display("FAIL reset_master_if: en=%b addr=%h rw=%b din=%h required 0", m_enable, m_addr, m_rw, m_data_in); end
    reset = 1'b0;
    exp_ptr = N - 1;
    exp_rdata = 8'h00;
  endtask

  task automatic test_write();
    obs_t o;
    cap_q.delete();
    do_txn(0, 7'h50, 1'b0, 8'hA5, o);
    checks++; if (o.to || o.lat != 1 || o.g !== 4'b0001) begin errors++; $display("FAIL write_grant: gnt=%b latency=%0d required 0001 latency 1", o.g, o.lat); end
    checks++; if (o.ge !== 1'b1 || o.ga !== 7'h50 || o.gd !== 8'hA5) begin errors++; $display("FAIL write_launch: en=%b addr=%h din=%h required 1 50 A5", o.ge, o.ga, o.gd); end
    checks++; if (o.dn !== 4'b0001 || o.e !== 1'b0 || o.en_end !== 1'b0) begin errors++; $display("FAIL write_done: done=%b err=%b en=%b required 0001 0 0", o.dn, o.e, o.en_end); end
    tick();
    checks++; if (done !== '0) begin errors++; $display("FAIL write_done_pulse: done=%b one cycle later, required 0", done); end
    checks++; if (cap_q.size() != 1 || cap_q[0] !== 16'hA0A5) begin errors++; $display("FAIL write_bus: captured %0d bytes first=%h required A0A5", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 16'h0); end
    exp_ptr = 0;
  endtask

  task automatic test_read();
    obs_t o;
    do_txn(2, 7'h3C, 1'b1, 8'($urandom), o);
    checks++; if (o.to || o.dn !== 4'b0100 || o.e !== 1'b0 || o.rd !== 8'h5A) begin errors++; $display("FAIL read_3c: done=%b err=%b rdata=%h required 0100 0 5A", o.dn, o.e, o.rd); end
    exp_rdata = 8'h5A;
    do_txn(1, 7'($urandom), 1'b0, 8'($urandom), o);
    checks++; if (o.to || o.dn !== 4'b0010 || o.rd !== 8'h5A) begin errors++; $display("FAIL read_hold: done=%b rdata=%h required 0010 5A", o.dn, o.rd); end
    exp_ptr = 1;
  endtask

  task automatic test_random();
    obs_t o;
    int r, w;
    logic [6:0] a;
    logic rw;
    logic [7:0] d;
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, N - 1);
      a = 7'($urandom); rw = 1'($urandom); d = 8'($urandom);
      cap_q.delete();
      do_txn(r, a, rw, d, o);
      w = rr_next(exp_ptr, 4'(1 << r));
      exp_ptr = w;
      if (rw) exp_rdata = slave_mem[a];
      checks++; if (o.to || o.g !== 4'(1 << w) || o.dn !== 4'(1 << w) || o.e !== 1'b0) begin errors++; $display("FAIL random_%0d_handshake: gnt=%b done=%b err=%b required grant/done to %0d err 0", it, o.g, o.dn, o.e, w); end
      checks++; if (o.rd !== exp_rdata) begin errors++; $display("FAIL random_%0d_rdata: rdata=%h required %h", it, o.rd, exp_rdata); end
      checks++; if (cap_q.size() != 1 || cap_q[0] !== {a, rw, d}) begin errors++; $display("FAIL random_%0d_payload: captured=%h required %h", it, (cap_q.size() > 0) ? cap_q[0] : 16'h0, {a, rw, d}); end
    end
  endtask

  // Hold a request mask until n transactions completed, then check the grant order.
  task automatic run_batch(input string name, input logic [N-1:0] mask, input int n);
    int d0, exp_order [$];
    d0 = done_cnt;
    grant_log.delete();
    done_log.delete();
    for (int r = 0; r < N; r++) set_payload(r, 7'($urandom), 1'b0, 8'($urandom));
    req = mask;
    for (int k = 0; k < 20000 && done_cnt < d0 + n; k++) tick();
    req = '0;
    repeat (5) tick();
    for (int t = 0; t < n; t++) begin
      exp_ptr = rr_next(exp_ptr, mask);
      exp_order.push_back(exp_ptr);
    end
    checks++; if (grant_log.size() != n || done_log.size() != n) begin errors++; $display("FAIL %s_count: grants=%0d dones=%0d required %0d", name, grant_log.size(), done_log.size(), n); end
    for (int t = 0; t < n && t < grant_log.size() && t < done_log.size(); t++) begin
      checks++; if (grant_log[t] != exp_order[t] || done_log[t] != exp_order[t]) begin errors++; $display("FAIL %s_order_%0d: grant=%0d done=%0d required %0d", name, t, grant_log[t], done_log[t], exp_order[t]); end
    end
    checks++; if (onehot_err != 0 || overlap_err != 0) begin errors++; $display("FAIL %s_onehot_overlap: onehot_err=%0d overlap_err=%0d required 0 0", name, onehot_err, overlap_err); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s_rdata: rdata=%h required %h", name, rdata, exp_rdata); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    run_batch("round_robin", 4'b1111, 8);
  endtask

  task automatic test_timeout_launch();
    obs_t o;
    mode = 1;
    tick();
    do_txn(1, 7'($urandom), 1'b1, 8'($urandom), o);
    checks++; if (o.to || o.dn !== 4'b0010 || o.e !== 1'b1 || o.en_end !== 1'b0) begin errors++; $display("FAIL timeout_launch_done: done=%b err=%b en=%b required 0010 1 0", o.dn, o.e, o.en_end); end
    checks++; if (o.en < T || o.en > T + 2 || o.rd !== exp_rdata) begin errors++; $display("FAIL timeout_launch_len: enable cycles=%0d rdata=%h required %0d..%0d and %h", o.en, o.rd, T, T + 2, exp_rdata); end
    exp_ptr = 1;
    mode = 0;
    repeat (2) tick();
  endtask

  task automatic test_timeout_busy();
    obs_t o;
    mode = 2;
    do_txn(3, 7'($urandom), 1'b1, 8'($urandom), o);
    checks++; if (o.to || o.dn !== 4'b1000 || o.e !== 1'b1 || o.en_end !== 1'b0) begin errors++; $display("FAIL timeout_busy_done: done=%b err=%b en=%b required 1000 1 0", o.dn, o.e, o.en_end); end
    checks++; if (o.bz < T || o.bz > T + 3 || o.rd !== exp_rdata) begin errors++; $display("FAIL timeout_busy_len: busy cycles=%0d rdata=%h required %0d..%0d and %h", o.bz, o.rd, T, T + 3, exp_rdata); end
    exp_ptr = 3;
    mode = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset_busy();
    int d0, k;
    mode = 2;
    set_payload(3, 7'($urandom), 1'b1, 8'($urandom));
    req[3] = 1'b1;
    for (k = 0; k < 100 && gnt[3] !== 1'b1; k++) tick();
    req[3] = 1'b0;
    for (k = 0; k < 100 && (m_enable !== 1'b0 || m_ready !== 1'b0); k++) tick();
    repeat (3) tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL reset_busy_setup: gnt=%b required 1000", gnt); end
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    checks++; if (gnt !== '0 || done !== '0 || err !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL reset_busy_outputs: gnt=%b done=%b err=%b rdata=%h required 0", gnt, done, err, rdata); end
    checks++; if ({m_enable, m_addr, m_rw, m_data_in} !== 17'h0) begin errors++; $display("FAIL reset_busy_master_if: en=%b addr=%h rw=%b din=%h required 0", m_enable, m_addr, m_rw, m_data_in); end
    mode = 0;
    reset = 1'b0;
    exp_ptr = N - 1;
    exp_rdata = 8'h00;
    repeat (3) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL reset_busy_no_done: dones=%0d required %0d", done_cnt - d0, 0); end
    run_batch("after_reset", 4'b1001, 2);
  endtask

  task automatic test_withdraw();
    int d0;
    mode = 3;
    repeat (2) tick();
    grant_log.delete();
    d0 = done_cnt;
    set_payload(1, 7'($urandom), 1'b0, 8'($urandom));
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    repeat (2) tick();
    mode = 0;
    repeat (20) tick();
    checks++; if (grant_log.size() != 0 || gnt !== '0 || done_cnt != d0) begin errors++; $display("FAIL withdraw: grants=%0d gnt=%b dones=%0d required 0", grant_log.size(), gnt, done_cnt - d0); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) slave_mem[i] = 8'($urandom);
    slave_mem[7'h3C] = 8'h5A;
    test_reset();
    test_write();
    test_read();
    test_random();
    test_round_robin();
    test_timeout_launch();
    test_timeout_busy();
    test_reset_busy();
    test_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
